// File: rtl/cfg_sequencer.sv
// Camera configuration sequencer: walks the {reg,val} ROM from address 0 and
// issues one SCCB register write per entry, honouring delay and end markers.
module cfg_sequencer #(
    parameter logic [7:0] CAM_ID       = 8'h42,
    parameter int         DELAY_CYCLES = 2_500_000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_valid,
    input  logic        i_sccb_ready,
    output logic [7:0]  o_sccb_id,
    output logic [7:0]  o_sccb_reg,
    output logic [7:0]  o_sccb_data,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [15:0] END_MARK = 16'hFF_FF;
    localparam logic [15:0] DLY_MARK = 16'hFF_F0;
    localparam logic [7:0]  LAST_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        DELAY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       addr, addr_nxt;
    logic             valid, valid_nxt;
    logic [7:0]       sreg, sreg_nxt;
    logic [7:0]       sdata, sdata_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            addr  <= 8'd0;
            valid <= 1'b0;
            sreg  <= 8'd0;
            sdata <= 8'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            valid <= valid_nxt;
            sreg  <= sreg_nxt;
            sdata <= sdata_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        valid_nxt = valid;
        sreg_nxt  = sreg;
        sdata_nxt = sdata;
        cnt_nxt   = cnt;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_nxt = FETCH;
                    addr_nxt  = 8'd0;
                end
            end
            FETCH: begin
                // ROM registers its output during this cycle
                state_nxt = DECODE;
            end
            DECODE: begin
                if (i_rom_data == END_MARK) begin
                    state_nxt = DONE;
                end else if (i_rom_data == DLY_MARK) begin
                    state_nxt = DELAY;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = WRITE;
                    valid_nxt = 1'b1;
                    sreg_nxt  = i_rom_data[15:8];
                    sdata_nxt = i_rom_data[7:0];
                end
            end
            WRITE: begin
                if (i_sccb_ready) begin
                    valid_nxt = 1'b0;
                    if (addr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                        addr_nxt  = addr + 8'd1;
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                        addr_nxt  = addr + 8'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_rom_addr   = addr;
    assign o_sccb_valid = valid;
    assign o_sccb_id    = CAM_ID;
    assign o_sccb_reg   = sreg;
    assign o_sccb_data  = sdata;
    assign o_busy       = (state != IDLE) && (state != DONE);
    assign o_done       = (state == DONE);

endmodule

// File: tb/tb_cfg_sequencer.sv
// Scoreboard bench for cfg_sequencer: a ROM-walking model queues expected
// writes, a monitor pops and compares every accepted SCCB transfer.
module tb_cfg_sequencer;

    localparam int DLY = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  rom_addr, sid, sreg, sdat;
    logic [15:0] rom_q;
    logic        valid, busy, done;

    cfg_sequencer #(.CAM_ID(8'h42), .DELAY_CYCLES(DLY)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_q),
        .o_sccb_valid(valid), .i_sccb_ready(ready),
        .o_sccb_id(sid), .o_sccb_reg(sreg), .o_sccb_data(sdat),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:255];
    always @(posedge clk) rom_q <= rom[rom_addr];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_fire = 0;
    int n_xfer = 0;
    int rdy_mode = 0;
    logic [15:0] exp_q[$];
    int gap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ready: 0 = always high, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: ready = 1'b1;
                1: ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'b0;
            endcase
        end
    end

    logic       pv = 1'b0, pfire = 1'b0;
    logic [7:0] preg = 8'd0, pdat = 8'd0;
    always @(negedge clk) begin
        if (!rstn) begin
            pv = 1'b0;
            pfire = 1'b0;
        end else begin
            if (valid && pv && !pfire) begin
                check("hold_reg", 32'(sreg), 32'(preg));
                check("hold_data", 32'(sdat), 32'(pdat));
            end
            if (valid && !pv) gap_q.push_back(cyc - last_fire);
            if (valid && ready) begin
                n_xfer++;
                last_fire = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL xfer: got %02h/%02h expected no transfer", sreg, sdat);
                end else begin
                    check("xfer", 32'({sreg, sdat}), 32'(exp_q.pop_front()));
                end
            end
            pv = valid;
            pfire = valid && ready;
            preg = sreg;
            pdat = sdat;
        end
    end

    // Reference: every entry up to the end marker (or entry 255) except delay markers is written.
    task automatic push_model(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] != 16'hFFF0) begin
                exp_q.push_back(rom[i]);
                n++;
            end
        end
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFFFF || w == 16'hFFF0) w = w ^ 16'h0001;
        return w;
    endfunction

    task automatic fill_random(input int nw, input bit with_delay);
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < nw; i++) begin
            if (with_delay && $urandom_range(0, 4) == 0) rom[i] = 16'hFFF0;
            else rom[i] = rnd_word();
        end
        if (nw < 256) rom[nw] = 16'hFFFF;
    endtask

    task automatic do_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) check({nm, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run(input string nm, input int limit);
        int n, cy;
        push_model(n);
        do_start();
        wait_done(nm, limit, cy);
        check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, cy, x0;
        bit seen;

        // reset state
        fill_random(4, 0);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_reg", 32'(sreg), 32'd0);
        check("rst_data", 32'(sdat), 32'd0);
        check("rst_id", 32'(sid), 32'h42);
        @(posedge clk);
        #3 rstn = 1'b1;

        // T1: two writes, done eight cycles after start edge
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1204; rom[1] = 16'h1180; rom[2] = 16'hFFFF;
        rdy_mode = 0;
        x0 = n_xfer;
        gap_q.delete();
        push_model(n);
        do_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done("t1", 100, cy);
        check("t1_done_latency", 32'(cy), 32'd8);
        check("t1_xfers", 32'(n_xfer - x0), 32'd2);
        check("t1_addr", 32'(rom_addr), 32'd2);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        if (gap_q.size() >= 2) check("t1_gap", 32'(gap_q[1]), 32'd3);
        else check("t1_gap_count", 32'(gap_q.size()), 32'd2);

        // T2: delay marker spacing
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
        gap_q.delete();
        run("t2", 200);
        if (gap_q.size() >= 2) check("t2_gap", 32'(gap_q[1]), 32'(2 + DLY + 3));
        else check("t2_gap_count", 32'(gap_q.size()), 32'd2);

        // T3: ready held low for 20 cycles during first write
        fill_random(4, 0);
        rdy_mode = 2;
        push_model(n);
        do_start();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        check("t3_valid_seen", 32'(valid), 32'd1);
        x0 = n_xfer;
        repeat (20) @(posedge clk);
        #1;
        check("t3_valid_held", 32'(valid), 32'd1);
        check("t3_no_xfer_stalled", 32'(n_xfer - x0), 32'd0);
        rdy_mode = 0;
        wait_done("t3", 200, cy);
        check("t3_xfers", 32'(n_xfer - x0), 32'(n));
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // T4: start pulses while busy are ignored; restart after done repeats the run
        fill_random(10, 1);
        rdy_mode = 1;
        push_model(n);
        do_start();
        cy = 0;
        while (!done && cy < 2000) begin
            @(posedge clk);
            #1;
            cy++;
            if (cy == 3 || cy == 7) begin
                check("t4_busy_at_pulse", 32'(busy), 32'd1);
                #1 start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        run("t4_rerun", 2000);

        // T5: asynchronous reset mid-write
        fill_random(6, 0);
        rdy_mode = 2;
        push_model(n);
        do_start();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        check("t5_in_write", 32'(valid), 32'd1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_addr", 32'(rom_addr), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3 rstn = 1'b1;
        rdy_mode = 0;
        x0 = n_xfer;
        repeat (10) @(posedge clk);
        #1;
        check("t5_idle_valid", 32'(valid), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_done", 32'(done), 32'd0);
        check("t5_idle_xfers", 32'(n_xfer - x0), 32'd0);

        // random sequences with delays and random ready
        for (int k = 0; k < 4; k++) begin
            fill_random(int'($urandom_range(1, 20)), 1);
            rdy_mode = 1;
            run("rand", 3000);
        end

        // T6: 256 writes, no end marker
        fill_random(256, 0);
        rom[5] = 16'hFF12;
        rdy_mode = 1;
        x0 = n_xfer;
        run("t6", 6000);
        check("t6_xfers", 32'(n_xfer - x0), 32'd256);
        check("t6_addr", 32'(rom_addr), 32'hFF);
        check("t6_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
